// File: rtl/sobel_pkg.sv
// Shared types for the Sobel 3x3 window generator.
// Pixel width is set here; win_t holds the nine taps, with tap[0] top-left and tap[8] bottom-right.
package sobel_pkg;

  localparam int unsigned PIX_W = 8;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef struct packed {
    pixel_t [8:0] tap;
  } win_t;

endpackage

// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out stream bundle for sobel_window_gen.
// SOBEL_WIN_COORD_EN adds the out_x/out_y centre coordinate signals.
interface sobel_window_gen_if #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
);
  import sobel_pkg::*;

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  logic   in_valid;
  logic   in_ready;
  logic   in_sof;
  pixel_t in_pixel;
  logic   out_valid;
  logic   out_ready;
  pixel_t p0, p1, p2, p3, p4, p5, p6, p7, p8;
  logic   out_last;
`ifdef SOBEL_WIN_COORD_EN
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;

  modport master (
    output in_valid, in_sof, in_pixel, out_ready,
    input  in_ready, out_valid, p0, p1, p2, p3, p4, p5, p6, p7, p8, out_last, out_x, out_y
  );
  modport slave (
    input  in_valid, in_sof, in_pixel, out_ready,
    output in_ready, out_valid, p0, p1, p2, p3, p4, p5, p6, p7, p8, out_last, out_x, out_y
  );
`else
  modport master (
    output in_valid, in_sof, in_pixel, out_ready,
    input  in_ready, out_valid, p0, p1, p2, p3, p4, p5, p6, p7, p8, out_last
  );
  modport slave (
    input  in_valid, in_sof, in_pixel, out_ready,
    output in_ready, out_valid, p0, p1, p2, p3, p4, p5, p6, p7, p8, out_last
  );
`endif

endinterface

// File: rtl/sobel_line_buf.sv
// One-line pixel store with a write port and a combinational read port at the same column.
// Contents are deliberately not reset.
module sobel_line_buf #(
  parameter  int unsigned DEPTH = 640,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift register, 1-cycle latency.
// SOBEL_WIN_COORD_EN adds registered window-centre coordinates on out_x/out_y.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input logic               clk,
  input logic               rst,
  sobel_window_gen_if.slave bus
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  logic [XW-1:0] col_q, col_d, x;
  logic [YW-1:0] row_q, row_d, y;
  logic          accept, win_done;
  pixel_t        lb1_rd, lb2_rd;
  win_t          win_q, win_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [XW-1:0] ox_q, ox_d;
  logic [YW-1:0] oy_q, oy_d;

  assign bus.in_ready = !rst && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // An accepted start-of-frame pixel is forced to (0,0) regardless of the counters.
  assign x        = bus.in_sof ? '0 : col_q;
  assign y        = bus.in_sof ? '0 : row_q;
  assign win_done = (x >= XW'(2)) && (y >= YW'(2));

  // lb1 holds row y-1; lb2 is fed from lb1's old value so it holds row y-2.
  sobel_line_buf #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (x),
    .wdata (bus.in_pixel),
    .rdata (lb1_rd)
  );

  sobel_line_buf #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_lb2 (
    .clk   (clk),
    .we    (accept),
    .addr  (x),
    .wdata (lb1_rd),
    .rdata (lb2_rd)
  );

  always_comb begin
    win_d       = win_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    col_d       = col_q;
    row_d       = row_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d.tap[3*r]   = win_q.tap[3*r+1];
        win_d.tap[3*r+1] = win_q.tap[3*r+2];
      end
      win_d.tap[2] = lb2_rd;
      win_d.tap[5] = lb1_rd;
      win_d.tap[8] = bus.in_pixel;
      out_valid_d  = win_done;
      out_last_d   = (x == XW'(IMG_W-1)) && (y == YW'(IMG_H-1));
      ox_d         = x - XW'(1);
      oy_d         = y - YW'(1);
      if (x == XW'(IMG_W-1)) begin
        col_d = '0;
        row_d = (y == YW'(IMG_H-1)) ? '0 : y + YW'(1);
      end else begin
        col_d = x + XW'(1);
        row_d = y;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
    end else begin
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      col_q       <= col_d;
      row_q       <= row_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.p0        = win_q.tap[0];
  assign bus.p1        = win_q.tap[1];
  assign bus.p2        = win_q.tap[2];
  assign bus.p3        = win_q.tap[3];
  assign bus.p4        = win_q.tap[4];
  assign bus.p5        = win_q.tap[5];
  assign bus.p6        = win_q.tap[6];
  assign bus.p7        = win_q.tap[7];
  assign bus.p8        = win_q.tap[8];

`ifdef SOBEL_WIN_COORD_EN
  assign bus.out_x = ox_q;
  assign bus.out_y = oy_q;
`else
  logic unused_coord;
  assign unused_coord = ^{ox_q, oy_q};
`endif

endmodule
